// File: rtl/out_fifo_arbiter_if.sv
// Bus bundle between the output FIFO, the two requesters and out_fifo_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding logic.
interface out_fifo_arbiter_if #(
    parameter int DW = 32
);
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          req0;
    logic          req1;
    logic          ack1;
    logic [1:0]    gnt;
    logic [DW-1:0] dout;
    logic          dout_valid0;
    logic          dout_valid1;
    logic          timeout;

    modport master (
        input  fifo_rd_data, fifo_empty, req0, req1, ack1,
        output fifo_rd_en, gnt, dout, dout_valid0, dout_valid1, timeout
    );

    modport slave (
        output fifo_rd_data, fifo_empty, req0, req1, ack1,
        input  fifo_rd_en, gnt, dout, dout_valid0, dout_valid1, timeout
    );
endinterface

// File: rtl/out_fifo_arbiter.sv
// Round-robin arbiter that pops a FWFT output FIFO and delivers words to two requesters.
// Define OUT_ARB_WDOG_EN to build in the starvation watchdog that drives timeout.
module out_fifo_arbiter #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    out_fifo_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    gnt_q;
    logic [DW-1:0] dout_q;
    logic          pend0;
    logic          prio1;
    logic          elig0;
    logic          elig1;
    logic          pick1;
    logic          rd_en;
    logic          valid0;
    logic          valid1;

    // A live req0 pulse counts as eligible so service starts the very next cycle.
    assign elig0 = pend0 | bus.req0;
    assign elig1 = bus.req1;
    assign pick1 = elig1 & (~elig0 | prio1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!bus.fifo_empty && (elig0 || elig1)) state_next = POP;
            POP:     if (!bus.fifo_empty) state_next = DELIVER;
            DELIVER: if (gnt_q[0] || bus.ack1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en  = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        case (state)
            POP:     rd_en = ~bus.fifo_empty;
            DELIVER: begin
                valid0 = gnt_q[0];
                valid1 = gnt_q[1];
            end
            default: ;
        endcase
    end

    // Grant, round-robin pointer, pending flag and the captured word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt_q  <= 2'b00;
            prio1  <= 1'b0;
            pend0  <= 1'b0;
            dout_q <= '0;
        end else begin
            pend0 <= bus.req0 | (pend0 & ~valid0);
            if (state == IDLE && state_next == POP) begin
                gnt_q <= pick1 ? 2'b10 : 2'b01;
                prio1 <= ~pick1;
            end else if (state == DELIVER && state_next == IDLE) begin
                gnt_q <= 2'b00;
            end
            if (rd_en) begin
                dout_q <= bus.fifo_rd_data;
            end
        end
    end

    assign bus.fifo_rd_en  = rd_en;
    assign bus.gnt         = gnt_q;
    assign bus.dout        = dout_q;
    assign bus.dout_valid0 = valid0;
    assign bus.dout_valid1 = valid1;

`ifdef OUT_ARB_WDOG_EN
    localparam logic [16:0] WDOG_LIMIT = 17'(TIMEOUT);

    logic [15:0] wdog_cnt;
    logic [16:0] wdog_inc;
    logic        wdog_run;
    logic        timeout_q;

    assign wdog_run = (state == IDLE) & (pend0 | bus.req1) & bus.fifo_empty;
    assign wdog_inc = {1'b0, wdog_cnt} + 17'd1;

    // Counter saturates so a very long stall cannot wrap back below the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdog_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if (!wdog_run) begin
                wdog_cnt <= 16'd0;
            end else if (wdog_cnt != 16'hFFFF) begin
                wdog_cnt <= wdog_inc[15:0];
            end
            if (valid0 || valid1) begin
                timeout_q <= 1'b0;
            end else if (wdog_run && wdog_inc >= WDOG_LIMIT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    // TIMEOUT is always positive, so this is a constant 0 that keeps the parameter referenced.
    assign bus.timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_out_fifo_arbiter.sv
// Directed bench for out_fifo_arbiter: a queue-based FWFT FIFO model feeds the DUT and a
// scoreboard of expected (requester, word) deliveries is checked as words come out.
module tb_out_fifo_arbiter;
    localparam int DW = 32;

    typedef struct {
        logic          who;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    out_fifo_arbiter_if #(.DW(DW)) bus();

    out_fifo_arbiter #(.DW(DW), .TIMEOUT(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    exp_t          sb[$];
    logic [DW-1:0] fifo_q[$];
    int            v1_at[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc_n = 0;
    int            n_rd = 0;
    int            n_v0 = 0;
    int            n_v1 = 0;
    logic          rd_en_prev = 1'b0;
    logic          prev_v1 = 1'b0;
    logic [DW-1:0] prev_dout = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_sync();
        bus.fifo_empty   = (fifo_q.size() == 0);
        bus.fifo_rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] w, input logic expect_en, input logic who);
        exp_t e;
        fifo_q.push_back(w);
        fifo_sync();
        if (expect_en) begin
            e.who  = who;
            e.data = w;
            sb.push_back(e);
        end
    endtask

    task automatic deliver(input logic who, input logic [DW-1:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("sb_who", 32'(who), 32'(e.who));
            check("sb_data", data, e.data);
        end
    endtask

    // One clock: retire last cycle's handshake/pop, then sample mid-cycle.
    task automatic cycle();
        @(negedge clk);
        cyc_n++;
        if (prev_v1 && bus.ack1) deliver(1'b1, prev_dout);
        if (rd_en_prev && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_sync();
        #1;
        check("rd_en_while_empty", 32'(bus.fifo_rd_en & bus.fifo_empty), 32'd0);
        if (bus.fifo_rd_en) n_rd++;
        if (bus.dout_valid0) begin
            n_v0++;
            deliver(1'b0, bus.dout);
        end
        if (bus.dout_valid1) begin
            n_v1++;
            v1_at.push_back(cyc_n);
        end
        rd_en_prev = bus.fifo_rd_en;
        prev_v1    = bus.dout_valid1;
        prev_dout  = bus.dout;
    endtask

    task automatic do_reset();
        rd_en_prev = 1'b0;
        prev_v1    = 1'b0;
        resetn     = 1'b0;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.ack1   = 1'b0;
        fifo_q.delete();
        fifo_sync();
        repeat (2) cycle();
        resetn = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        check({tag, "_dout"}, bus.dout, 32'd0);
        check({tag, "_v0"}, 32'(bus.dout_valid0), 32'd0);
        check({tag, "_v1"}, 32'(bus.dout_valid1), 32'd0);
        check({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: observed timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.ack1 = 1'b0;
        fifo_sync();

        // Reset values
        resetn = 1'b0;
        repeat (3) cycle();
        check_all_zero("reset");
        resetn = 1'b1;
        cycle();

        // Single req0 pulse: pop next cycle, deliver the one after
        push(32'hA5A5_0001, 1'b1, 1'b0);
        bus.req0 = 1'b1;
        cycle();
        bus.req0 = 1'b0;
        check("t2_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        check("t2_gnt_pop", 32'(bus.gnt), 32'd1);
        check("t2_v0_early", 32'(bus.dout_valid0), 32'd0);
        cycle();
        check("t2_v0", 32'(bus.dout_valid0), 32'd1);
        check("t2_dout", bus.dout, 32'hA5A5_0001);
        check("t2_gnt_deliver", 32'(bus.gnt), 32'd1);
        cycle();
        check("t2_gnt_idle", 32'(bus.gnt), 32'd0);
        check("t2_v0_done", 32'(bus.dout_valid0), 32'd0);
        check("t2_rd_en_idle", 32'(bus.fifo_rd_en), 32'd0);

        // Both requesters from reset: 0 first, then 1 held until ack1
        do_reset();
        push(32'h11, 1'b1, 1'b0);
        push(32'h22, 1'b1, 1'b1);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        cycle();
        bus.req0 = 1'b0;
        check("t3_gnt0", 32'(bus.gnt), 32'd1);
        cycle();
        check("t3_v0", 32'(bus.dout_valid0), 32'd1);
        cycle();
        check("t3_gnt_idle", 32'(bus.gnt), 32'd0);
        check("t3_v1_idle", 32'(bus.dout_valid1), 32'd0);
        cycle();
        check("t3_gnt1", 32'(bus.gnt), 32'd2);
        check("t3_rd_en1", 32'(bus.fifo_rd_en), 32'd1);
        cycle();
        check("t3_v1", 32'(bus.dout_valid1), 32'd1);
        bus.req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t3_v1_hold", 32'(bus.dout_valid1), 32'd1);
            check("t3_dout_hold", bus.dout, 32'h22);
        end
        bus.ack1 = 1'b1;
        cycle();
        bus.ack1 = 1'b0;
        check("t3_v1_after_ack", 32'(bus.dout_valid1), 32'd0);
        check("t3_gnt_after_ack", 32'(bus.gnt), 32'd0);

        // Merged req0 pulses while the FIFO is empty
        for (int i = 0; i < 3; i++) begin
            bus.req0 = 1'b1;
            cycle();
            bus.req0 = 1'b0;
            cycle();
        end
        n_rd = 0;
        n_v0 = 0;
        push(32'h33, 1'b1, 1'b0);
        repeat (6) cycle();
        check("t4_pops", 32'(n_rd), 32'd1);
        check("t4_deliveries", 32'(n_v0), 32'd1);
        n_rd = 0;
        push(32'h55, 1'b0, 1'b0);
        repeat (4) cycle();
        check("t4_pend0_cleared", 32'(n_rd), 32'd0);
        fifo_q.delete();
        fifo_sync();

        // Streaming to requester 1 with ack1 tied high
        v1_at.delete();
        n_v1 = 0;
        bus.req1 = 1'b1;
        bus.ack1 = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i), 1'b1, 1'b1);
        repeat (14) cycle();
        bus.req1 = 1'b0;
        cycle();
        bus.ack1 = 1'b0;
        check("t5_count", 32'(n_v1), 32'd4);
        for (int i = 1; i < v1_at.size(); i++) begin
            check("t5_spacing", 32'(v1_at[i] - v1_at[i-1]), 32'd3);
        end

        // Starvation watchdog
        do_reset();
        bus.req1 = 1'b1;
        repeat (7) cycle();
        check("t6_timeout_before", 32'(bus.timeout), 32'd0);
        cycle();
`ifdef OUT_ARB_WDOG_EN
        check("t6_timeout_set", 32'(bus.timeout), 32'd1);
`else
        check("t6_timeout_tied", 32'(bus.timeout), 32'd0);
`endif
        bus.ack1 = 1'b1;
        push(32'h44, 1'b1, 1'b1);
        cycle();
        cycle();
        check("t6_v1", 32'(bus.dout_valid1), 32'd1);
        check("t6_dout", bus.dout, 32'h44);
        cycle();
        check("t6_timeout_cleared", 32'(bus.timeout), 32'd0);
        bus.req1 = 1'b0;
        bus.ack1 = 1'b0;
        cycle();

        // Reset during DELIVER discards the held word
        push(32'h77, 1'b0, 1'b0);
        bus.req1 = 1'b1;
        w = 0;
        do begin
            cycle();
            w++;
        end while (!bus.dout_valid1 && w < 10);
        check("t7_deliver_reached", 32'(bus.dout_valid1), 32'd1);
        bus.req1 = 1'b0;
        resetn = 1'b0;
        #1;
        check_all_zero("t7_async");
        cycle();
        cycle();
        resetn = 1'b1;
        bus.ack1 = 1'b1;
        n_v0 = 0;
        n_v1 = 0;
        repeat (6) cycle();
        bus.ack1 = 1'b0;
        check("t7_no_replay", 32'(n_v0 + n_v1), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/out_fifo_arbiter.md
OUT_FIFO_ARBITER -- requirements
Module: out_fifo_arbiter

Interface
REQ-001 Parameter DW, default 32, data word width.
REQ-002 Parameter TIMEOUT, default 1024, starvation watchdog limit in cycles; legal range 2..65535.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 fifo_rd_data  in  DW  output-FIFO head word; valid in the same cycle as fifo_rd_en (first-word-fall-through).
REQ-006 fifo_empty  in  1  output-FIFO empty flag.
REQ-007 fifo_rd_en  out  1  pop strobe to output FIFO.
REQ-008 req0  in  1  requester 0 (button edge pulse); single-cycle pulse.
REQ-009 req1  in  1  requester 1 (UART streamer); level request.
REQ-010 ack1  in  1  requester 1 accepts the presented word.
REQ-011 gnt  out  2  one-hot grant; bit0 = requester 0, bit1 = requester 1.
REQ-012 dout  out  DW  delivered word.
REQ-013 dout_valid0  out  1  single-cycle delivery strobe to requester 0.
REQ-014 dout_valid1  out  1  delivery strobe to requester 1, held until ack1.
REQ-015 timeout  out  1  sticky starvation flag.

Function
REQ-016 The block shall be the sole reader of the output FIFO.
REQ-017 A req0 pulse shall set a sticky pend0 bit; a further req0 while pend0=1 shall merge and not be counted.
REQ-018 pend0 shall clear in the cycle requester 0's word is delivered; a req0 in that same cycle shall keep pend0=1.
REQ-019 FSM states: IDLE, POP, DELIVER.
REQ-020 IDLE->POP when fifo_empty=0 and (pend0 or req1); gnt shall be registered on this transition.
REQ-021 Both requesters eligible: grant the one not served last (round-robin); after reset, requester 0 has priority.
REQ-022 POP: fifo_rd_en=1 for exactly one cycle; dout registers fifo_rd_data; next state DELIVER.
REQ-023 DELIVER, gnt0: dout_valid0=1 for one cycle, then IDLE.
REQ-024 DELIVER, gnt1: dout_valid1=1 and dout stable until the cycle ack1=1, then IDLE.
REQ-025 Latency: eligible request in IDLE at cycle N -> fifo_rd_en at N+1 -> dout_valid at N+2; back-to-back service every 3 cycles minimum.
REQ-026 req1 deasserting after grant shall not cancel the transaction; the word shall be held until ack1.
REQ-027 ack1 outside DELIVER/gnt1 shall be ignored.
REQ-028 fifo_rd_en shall never assert while fifo_empty=1.
REQ-029 gnt shall be 2'b00 in IDLE and hold its one-hot value through POP and DELIVER.

Reset
REQ-030 resetn=0 shall asynchronously force state IDLE, pend0=0, round-robin pointer = requester 0, watchdog counter=0.
REQ-031 During reset: fifo_rd_en=0, gnt=0, dout=0, dout_valid0=0, dout_valid1=0, timeout=0.
REQ-032 Reset mid-transaction shall discard a popped but undelivered word; no replay.

Configuration
REQ-033 Macro OUT_ARB_WDOG_EN shall compile the starvation watchdog in or out.
REQ-034 With OUT_ARB_WDOG_EN defined: a 16-bit counter shall increment each cycle in IDLE while (pend0 or req1) and fifo_empty=1, and clear otherwise.
REQ-035 With OUT_ARB_WDOG_EN defined: timeout shall set when the counter reaches TIMEOUT, and shall clear on the next dout_valid0 or dout_valid1 cycle or on reset.
REQ-036 Without OUT_ARB_WDOG_EN: no counter shall be present and timeout shall be tied to 0; the port remains.

Verification
REQ-037 FIFO holds 0xA5A5_0001; req0 pulse at cycle 10 -> fifo_rd_en at 11, dout_valid0 at 12 with dout=0xA5A5_0001, gnt=01 during 11-12.
REQ-038 FIFO holds 0x11, 0x22; pend0 set and req1=1 simultaneously from reset -> requester 0 gets 0x11, then requester 1 gets 0x22; ack1 held low 5 cycles -> dout_valid1 stays high with dout stable, and state returns to IDLE the cycle after ack1.
REQ-039 FIFO empty; req0 pulsed 3 times -> single pend0; push 0x33 -> exactly one pop, one dout_valid0, pend0=0.
REQ-040 req1 held high, 4 words pushed, ack1 tied high -> 4 deliveries, 3-cycle spacing, fifo_rd_en never asserted with fifo_empty=1.
REQ-041 WDOG_EN, TIMEOUT=8, req1=1, FIFO empty -> timeout rises after 8 cycles in IDLE; push 0x44 -> timeout clears on dout_valid1; without the macro timeout stays 0.
REQ-042 resetn asserted during DELIVER with a word held for requester 1 -> all outputs 0 immediately; after release, no delivery of the held word.
